// File: rtl/print_unit.sv
// print_unit: double-dabble decimal printer for the print instruction.
// Define PRINT_SIGNED_EN to print value as two's complement with a '-' sign.
module print_unit #(
    parameter int DATA_W = 32,
    parameter int NDIG   = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              print,
    input  logic [DATA_W-1:0] value,
    output logic              stall,
    output logic              char_valid,
    output logic [7:0]        char_data,
    input  logic              char_ready,
    output logic              busy
);

    localparam int BW = 4 * NDIG;
    localparam int PW = $clog2(NDIG);
    localparam int CW = $clog2(DATA_W);

    typedef enum logic [2:0] {
        IDLE,
        CONVERT,
        EMIT,
        NEWLINE,
        DONE
`ifdef PRINT_SIGNED_EN
        , SIGN
`endif
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] shreg;
    logic [BW-1:0]     bcd;
    logic [BW-1:0]     adj;
    logic [BW-1:0]     bcd_n;
    logic [CW-1:0]     cnt;
    logic [PW-1:0]     ptr;
    logic [PW-1:0]     ptr_n;
`ifdef PRINT_SIGNED_EN
    logic              neg;
`endif

    function automatic logic [7:0] digit(
        input logic [BW-1:0] b,
        input logic [PW-1:0] i
    );
        digit = 8'h30;
        for (int k = 0; k < NDIG; k++)
            if (i == k[PW-1:0])
                digit = 8'h30 + {4'h0, b[4*k +: 4]};
    endfunction

    // add-3 correction, then shift one operand bit into the BCD field
    always_comb begin
        adj = bcd;
        for (int i = 0; i < NDIG; i++)
            if (bcd[4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        bcd_n = {adj[BW-2:0], shreg[DATA_W-1]};
        ptr_n = '0;
        for (int i = 0; i < NDIG; i++)
            if (bcd_n[4*i +: 4] != 4'h0)
                ptr_n = i[PW-1:0];
    end

    assign stall = print && (state != DONE);
    assign busy  = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            shreg      <= '0;
            bcd        <= '0;
            cnt        <= '0;
            ptr        <= '0;
            char_valid <= 1'b0;
            char_data  <= 8'h00;
`ifdef PRINT_SIGNED_EN
            neg        <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    char_valid <= 1'b0;
                    if (print) begin
`ifdef PRINT_SIGNED_EN
                        neg   <= value[DATA_W-1];
                        shreg <= value[DATA_W-1] ? ~value + 1'b1 : value;
`else
                        shreg <= value;
`endif
                        bcd   <= '0;
                        cnt   <= '0;
                        state <= CONVERT;
                    end
                end
                CONVERT: begin
                    bcd   <= bcd_n;
                    shreg <= shreg << 1;
                    cnt   <= cnt + 1'b1;
                    if (cnt == CW'(DATA_W - 1)) begin
                        ptr        <= ptr_n;
                        char_valid <= 1'b1;
`ifdef PRINT_SIGNED_EN
                        if (neg) begin
                            char_data <= 8'h2D;
                            state     <= SIGN;
                        end else begin
                            char_data <= digit(bcd_n, ptr_n);
                            state     <= EMIT;
                        end
`else
                        char_data <= digit(bcd_n, ptr_n);
                        state     <= EMIT;
`endif
                    end
                end
`ifdef PRINT_SIGNED_EN
                SIGN: begin
                    if (char_ready) begin
                        char_data <= digit(bcd, ptr);
                        state     <= EMIT;
                    end
                end
`endif
                EMIT: begin
                    if (char_ready) begin
                        if (ptr == '0) begin
                            char_data <= 8'h0A;
                            state     <= NEWLINE;
                        end else begin
                            ptr       <= ptr - 1'b1;
                            char_data <= digit(bcd, ptr - 1'b1);
                        end
                    end
                end
                NEWLINE: begin
                    if (char_ready) begin
                        char_valid <= 1'b0;
                        char_data  <= 8'h00;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_print_unit.sv
// tb_print_unit: directed checks of print_unit output lines and timing.
// Expected strings depend on PRINT_SIGNED_EN.
module tb_print_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        print;
    logic [31:0] value;
    logic        stall;
    logic        char_valid;
    logic [7:0]  char_data;
    logic        char_ready;
    logic        busy;

    print_unit #(.DATA_W(32), .NDIG(10)) dut (
        .clk        (clk),
        .reset      (reset),
        .print      (print),
        .value      (value),
        .stall      (stall),
        .char_valid (char_valid),
        .char_data  (char_data),
        .char_ready (char_ready),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int ntests = 0;
    int nfail  = 0;

    logic [7:0] rx[$];
    int         rxc[$];
    logic       pv = 1'b0;
    logic       pr = 1'b0;
    logic [7:0] pd = 8'h00;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        ntests++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // sink: records transfers and checks that a stalled char is held
    always @(negedge clk) begin
        if (reset) begin
            pv = 1'b0;
        end else begin
            if (pv && !pr) begin
                chk("hold_valid", char_valid, 1);
                chk("hold_data", char_data, pd);
            end
            if (char_valid && char_ready) begin
                rx.push_back(char_data);
                rxc.push_back(cyc);
            end
            pv = char_valid;
            pr = char_ready;
            pd = char_data;
        end
    end

    task automatic clr();
        rx.delete();
        rxc.delete();
    endtask

    task automatic do_print(input logic [31:0] v, input bit hold,
                            input bit toggle, output int t0,
                            output int done_rel, output bit st0);
        logic [3:0] pat;
        int rel;
        bit found;
        pat = 4'b1001;
        value = v;
        print = 1'b1;
        t0 = cyc;
        done_rel = -1;
        st0 = 1'b0;
        found = 1'b0;
        if (toggle) char_ready = pat[0];
        for (int k = 0; k < 200 && !found; k++) begin
            @(negedge clk);
            rel = cyc - t0;
            if (rel == 0) st0 = stall;
            if (!stall) begin
                found = 1'b1;
                done_rel = rel;
            end else begin
                @(posedge clk);
                #1;
                if (toggle) char_ready = pat[(cyc - t0) % 4];
            end
        end
        if (!found) chk("timeout", 0, 1);
        @(posedge clk);
        #1;
        char_ready = 1'b1;
        if (!hold) begin
            print = 1'b0;
            chk("busy_idle", busy, 0);
        end
    endtask

    task automatic expect_str(input string tag, input string s);
        logic [7:0] g;
        chk({tag, "_len"}, rx.size(), s.len());
        for (int i = 0; i < s.len(); i++) begin
            g = (i < rx.size()) ? rx[i] : 8'h00;
            chk(tag, g, s[i]);
        end
    endtask

    task automatic expect_times(input int t0, input int first);
        for (int i = 0; i < rxc.size(); i++)
            chk("char_cycle", rxc[i] - t0, first + i);
    endtask

    int t0, t1, d0, d1;
    bit s0, s1;

    initial begin
        reset = 1'b1;
        print = 1'b0;
        value = 32'd0;
        char_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", char_valid, 0);
        chk("rst_data", char_data, 8'h00);
        chk("rst_busy", busy, 0);
        chk("rst_stall0", stall, 0);
        print = 1'b1;
        #1;
        chk("rst_stall1", stall, 1);
        print = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;

        clr();
        do_print(32'd0, 0, 0, t0, d0, s0);
        expect_str("zero", "0\n");
        expect_times(t0, 33);
        chk("zero_done", d0, 35);
        chk("zero_st0", s0, 1);

        clr();
        do_print(32'd1234567890, 0, 0, t0, d0, s0);
        expect_str("big", "1234567890\n");
        expect_times(t0, 33);
        chk("big_done", d0, 44);

        clr();
        do_print(32'hFFFFFFFF, 0, 0, t0, d0, s0);
`ifdef PRINT_SIGNED_EN
        expect_str("ones", "-1\n");
        chk("ones_done", d0, 36);
`else
        expect_str("ones", "4294967295\n");
        chk("ones_done", d0, 44);
`endif

        clr();
        do_print(32'd507, 0, 1, t0, d0, s0);
        expect_str("toggle", "507\n");

        clr();
        value = 32'd98;
        print = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        value = 32'hFFFFFFFF;
        repeat (31) @(posedge clk);
        #1;
        chk("r98_data", char_data, 8'h38);
        reset = 1'b1;
        print = 1'b0;
        #1;
        chk("r98_valid", char_valid, 0);
        chk("r98_busy", busy, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        expect_str("r98", "9");
        clr();
        do_print(32'd5, 0, 0, t0, d0, s0);
        expect_str("after_rst", "5\n");

        clr();
        do_print(32'd7, 1, 0, t0, d0, s0);
        do_print(32'd42, 0, 0, t1, d1, s1);
        expect_str("b2b", "7\n42\n");
        chk("b2b_done7", d0, 35);
        chk("b2b_done42", d1, 36);
        chk("b2b_stall", s1, 1);
        chk("b2b_gap", t1 - t0, 36);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
